// File: rtl/gray_counter_pkg.sv
// Shared types and helpers for the Gray-coded counter.
// Default width, direction encoding and a bin2gray helper.
package gray_counter_pkg;

  localparam int GRAY_CNT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_bin_to_gray.sv
// Combinational binary-to-Gray encoder.
// Mirror image of the Gray-to-binary decoder on the sampling side.
module gray_counter_bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs.
// Define GRAY_CNT_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_min;
  dir_t             dir;

  assign dir    = dir_t'(up);
  assign at_max = (bin == MAX);
  assign at_min = (bin == '0);

  // Next count: load beats step, step beats hold.
  always_comb begin
    bin_nxt  = bin;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        wrap_nxt = at_max;
`ifdef GRAY_CNT_SAT_EN
        if (!at_max) bin_nxt = bin + ONE;
`else
        bin_nxt = bin + ONE;
`endif
      end else begin
        wrap_nxt = at_min;
`ifdef GRAY_CNT_SAT_EN
        if (!at_min) bin_nxt = bin - ONE;
`else
        bin_nxt = bin - ONE;
`endif
      end
    end
  end

  gray_counter_bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_b2g (
    .b(bin_nxt),
    .g(gray_nxt)
  );

  // Both count forms and the wrap pulse come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered up/down binary counter that also outputs the same count in Gray code.
- It is the producer/encoder side of the team's Gray-to-binary decoder path. Gray code changes one bit per step, so the count can be sampled safely by logic on another clock.
- Both the Gray and binary forms of the count come straight from flops. No combinational path from inputs to outputs.

Parameters:
- WIDTH, 4, counter width in bits for both the binary and Gray forms (minimum 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable; one count step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray count; always equals bin ^ (bin >> 1).
- wrap  output  1  registered one-cycle pulse marking a boundary event (definition below).

Behaviour:
- Reset: while rst=1 at a clock edge, bin=0, gray=0, wrap=0. Reset overrides load and en, including mid-count.
- Priority at each edge: rst > load > en > hold.
- Load: bin <= load_val, gray <= bin2gray(load_val), wrap <= 0. Takes effect at the same edge, so values are visible the next cycle. en is ignored in that cycle.
- Step (en=1, load=0):
  - up=1: bin <= bin+1, modulo 2^WIDTH.
  - up=0: bin <= bin-1, modulo 2^WIDTH.
  - gray <= bin2gray(next bin), computed from the next value, so gray and bin never disagree.
- Hold (en=0, load=0): bin and gray unchanged; wrap <= 0.
- Latency: one cycle from an en/load sample to the updated outputs.
- wrap is 1 for exactly the cycle after either step:
  - up step from 2^WIDTH-1 to 0;
  - down step from 0 to 2^WIDTH-1.
  - In every other cycle wrap is 0. Back-to-back wraps (e.g. WIDTH=2 counting continuously) give one pulse per wrap event.
- Gray property: every step, including a wrap, changes exactly one gray bit. A load may change any number of bits.
- The up input may change every cycle; each step uses the up value sampled at that edge.

Optional Feature:
- Macro: GRAY_CNT_SAT_EN.
- Defined (saturating mode):
  - An up step at 2^WIDTH-1, or a down step at 0, leaves bin and gray unchanged.
  - wrap pulses for one cycle to flag the blocked overflow/underflow attempt.
  - All other behaviour is unchanged.
- Undefined: modulo wrap-around as described above.
- The port list is identical in both builds.

Decomposition:
- Shared package: bin2gray function, WIDTH default constant, and a direction typedef (DIR_DOWN=0, DIR_UP=1).
- Sub-module: a combinational bin_to_gray (WIDTH-parameterised, g = b ^ (b>>1)). It feeds the gray register from the next-bin value and is the natural counterpart of the existing decoder.

Test Plan (WIDTH=4):
- Reset, then en=1, up=1 for 16 cycles:
  - gray follows 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000;
  - wrap=1 only in the cycle bin returns to 0;
  - exactly one gray bit changes per step.
- From bin=0, en=1, up=0 for one cycle -> bin=1111, gray=1000, wrap=1. Without the macro, the next down step gives bin=1110, gray=1001, wrap=0.
- load=1, load_val=1010 with en=1 in the same cycle -> bin=1010, gray=1111, wrap=0 (load wins, no step).
- Count up to bin=0101, then assert rst with en=1 and load=1 -> next cycle bin=0000, gray=0000, wrap=0. Counting resumes from 0 after rst drops.
- Alternate up=1/0 each cycle starting at 0111 -> bin sequence 1000, 0111, 1000, 0111; gray 1100, 0100 alternating.
- With GRAY_CNT_SAT_EN: load 1111, then step up -> bin stays 1111, gray stays 1000, wrap=1 for one cycle. A down step then gives 1110 / 1001.
